cfu_nqueens_host: RTL and testbench

- Hardware initiator for the CFU command/response interface; it is the CPU-side master that drives the N-queens CFU without software.
- Runs init / kernel-loop / get_ret for each first-row column in a requested range and accumulates the solution count.
- Sits between a start/done control register block and the CFU's cmd/rsp ports.
- Handles both combinational responders (rsp_valid = cmd_valid, cmd_ready = rsp_ready) and responders with multi-cycle latency.

---
 rtl/cfu_nqueens_host.sv | 186 ++++++++++++++++++
 tb/tb_cfu_nqueens_host.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cfu_nqueens_host.sv
// ---------------------------------------------------------------------------
// cfu_nqueens_host
//
// Hardware initiator that drives the N-queens CFU over its cmd/rsp
// interface. For every first-row column in [col_first, col_last] it issues
// init(col), then kernel steps until the kernel reports 0, then get_ret.
// It accumulates the get_ret values into result.
//
// Handshake: a command transfers when cmd_valid & cmd_ready. A response
// transfers when rsp_valid & rsp_ready. cmd_valid rises on entry to an
// issuing state and holds, with a stable payload, until it transfers. It then
// stays low until that command's response transfers. Both transfers may land
// in the same cycle. rsp_ready stays high for the whole time a command is in
// progress, so a combinational responder (cmd_ready = rsp_ready) can accept.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   start                      run request (honoured in IDLE/DONE only)
//   col_first, col_last        inclusive column range, sampled on start
//   busy, done                 run in progress / one-cycle completion pulse
//   err                        0 ok, 1 range error, 2 kernel timeout
//   result                     sum of get_ret values (mod 2^32)
//   kernel_count               kernel commands accepted (saturating)
//   cmd_*                      command channel to the CFU
//   rsp_*                      response channel from the CFU
// ---------------------------------------------------------------------------
module cfu_nqueens_host #(
    parameter logic [31:0] KERNEL_LIMIT = 32'hFFFF_FFFF,
    parameter logic [9:0]  FID_INIT     = 10'd0,
    parameter logic [9:0]  FID_KERNEL   = 10'd1,
    parameter logic [9:0]  FID_GET_RET  = 10'd2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [4:0]  col_first,
    input  logic [4:0]  col_last,
    output logic        busy,
    output logic        done,
    output logic [1:0]  err,
    output logic [31:0] result,
    output logic [31:0] kernel_count,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic [9:0]  cmd_payload_function_id,
    output logic [31:0] cmd_payload_inputs_0,
    output logic [31:0] cmd_payload_inputs_1,
    output logic [31:0] cmd_payload_inputs_2,
    input  logic        rsp_valid,
    output logic        rsp_ready,
    input  logic [31:0] rsp_payload_outputs_0
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_INIT = 3'd1,
        S_KERN = 3'd2,
        S_GET  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t      state, state_next;
    logic        issued;        // current command transferred, awaiting response
    logic [4:0]  col;
    logic [4:0]  col_last_q;
    logic [31:0] per_col_cnt;

    logic        active;
    logic        cmd_fire;
    logic        rsp_fire;
    logic        resp_take;
    logic        start_ok;
    logic        range_bad;
    logic [32:0] cnt_after;
    logic        limit_hit;
    logic        kern_more;

    assign active    = (state == S_INIT) || (state == S_KERN) || (state == S_GET);
    assign cmd_valid = active && !issued;
    assign rsp_ready = active;
    assign busy      = active;

    assign cmd_fire  = cmd_valid && cmd_ready;
    assign rsp_fire  = rsp_valid && rsp_ready;
    // A response belongs to the current command only once that command has
    // transferred, either earlier or in this same cycle.
    assign resp_take = rsp_fire && (issued || cmd_fire);

    assign start_ok  = start && ((state == S_IDLE) || (state == S_DONE));
    // col_last is 5 bits wide, so the "beyond column 31" case cannot occur.
    assign range_bad = col_last < col_first;

    // Per-column kernel count including a command transferring this cycle.
    // The extra bit keeps the comparison exact at KERNEL_LIMIT = 2^32-1.
    assign cnt_after = {1'b0, per_col_cnt} + {32'd0, (state == S_KERN) && cmd_fire};
    assign limit_hit = cnt_after >= {1'b0, KERNEL_LIMIT};
    assign kern_more = rsp_payload_outputs_0 != 32'd0;

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE, S_DONE: begin
                if (start_ok) state_next = range_bad ? S_DONE : S_INIT;
            end
            S_INIT: begin
                if (resp_take) state_next = S_KERN;
            end
            S_KERN: begin
                if (resp_take) begin
                    if (!kern_more)     state_next = S_GET;
                    else if (limit_hit) state_next = S_DONE;
                    else                state_next = S_KERN;
                end
            end
            S_GET: begin
                if (resp_take) state_next = (col == col_last_q) ? S_DONE : S_INIT;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Payload depends only on state and col, so it is stable while cmd_valid waits.
    always_comb begin
        cmd_payload_function_id = 10'd0;
        cmd_payload_inputs_0    = 32'd0;
        case (state)
            S_INIT: begin
                cmd_payload_function_id = FID_INIT;
                cmd_payload_inputs_0    = {27'd0, col};
            end
            S_KERN:  cmd_payload_function_id = FID_KERNEL;
            S_GET:   cmd_payload_function_id = FID_GET_RET;
            default: ;
        endcase
    end

    assign cmd_payload_inputs_1 = 32'd0;
    assign cmd_payload_inputs_2 = 32'd0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            issued       <= 1'b0;
            col          <= 5'd0;
            col_last_q   <= 5'd0;
            per_col_cnt  <= 32'd0;
            done         <= 1'b0;
            err          <= 2'd0;
            result       <= 32'd0;
            kernel_count <= 32'd0;
        end else begin
            state <= state_next;
            // Entry into DONE, including a range-error start issued from DONE.
            done  <= (state_next == S_DONE) && ((state != S_DONE) || start_ok);

            if (resp_take)     issued <= 1'b0;
            else if (cmd_fire) issued <= 1'b1;

            if (start_ok) begin
                col_last_q   <= col_last;
                col          <= col_first;
                per_col_cnt  <= 32'd0;
                result       <= 32'd0;
                kernel_count <= 32'd0;
                err          <= range_bad ? 2'd1 : 2'd0;
            end

            if ((state == S_KERN) && cmd_fire) begin
                per_col_cnt <= per_col_cnt + 32'd1;
                if (kernel_count != 32'hFFFF_FFFF) kernel_count <= kernel_count + 32'd1;
            end

            if ((state == S_KERN) && resp_take && kern_more && limit_hit)
                err <= 2'd2;

            if ((state == S_GET) && resp_take) begin
                result <= result + rsp_payload_outputs_0;
                if (col != col_last_q) begin
                    col         <= col + 5'd1;
                    per_col_cnt <= 32'd0;
                end
            end
        end
    end

endmodule

// File: tb/tb_cfu_nqueens_host.sv
// ---------------------------------------------------------------------------
// tb_cfu_nqueens_host
//
// Directed bench for cfu_nqueens_host (built with KERNEL_LIMIT = 4) with a mock
// CFU. The mock runs in one of two modes. In combinational mode it drives
// rsp_valid = cmd_valid and cmd_ready = rsp_ready. In latent mode it holds
// cmd_ready low for 2 cycles and raises rsp_valid a few cycles after the
// command is accepted. Kernel and get_ret responses come from small tables.
// Expected commands are queued before each run and popped by the monitor
// when the DUT issues them.
// ---------------------------------------------------------------------------
module tb_cfu_nqueens_host;

  logic        clk;
  logic        reset;
  logic        start;
  logic [4:0]  col_first;
  logic [4:0]  col_last;
  logic        busy;
  logic        done;
  logic [1:0]  err;
  logic [31:0] result;
  logic [31:0] kernel_count;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [9:0]  fid;
  logic [31:0] in0, in1, in2;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;

  cfu_nqueens_host #(.KERNEL_LIMIT(32'd4)) dut (
    .clk                    (clk),
    .reset                  (reset),
    .start                  (start),
    .col_first              (col_first),
    .col_last               (col_last),
    .busy                   (busy),
    .done                   (done),
    .err                    (err),
    .result                 (result),
    .kernel_count           (kernel_count),
    .cmd_valid              (cmd_valid),
    .cmd_ready              (cmd_ready),
    .cmd_payload_function_id(fid),
    .cmd_payload_inputs_0   (in0),
    .cmd_payload_inputs_1   (in1),
    .cmd_payload_inputs_2   (in2),
    .rsp_valid              (rsp_valid),
    .rsp_ready              (rsp_ready),
    .rsp_payload_outputs_0  (rsp_data)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- counters / scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;
  int fire_cnt = 0;
  logic [41:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      $error("%s miscompare", tag);
    end
  endtask

  // ---------------- mock CFU ----------------
  logic        latent;
  logic        mock_clr;
  logic [31:0] kern_tab[0:15];
  logic [31:0] get_tab[0:15];
  int          kern_len;
  int          kern_idx, get_idx;
  logic [31:0] mock_data;
  logic        lat_pend;
  logic [1:0]  lat_dly;
  logic [31:0] lat_data;
  int          vcnt;

  always_comb begin
    mock_data = 32'hDEAD_BEEF;
    if (fid == 10'd1)      mock_data = (kern_idx < kern_len) ? kern_tab[kern_idx[3:0]] : 32'd1;
    else if (fid == 10'd2) mock_data = get_tab[get_idx[3:0]];
  end

  assign cmd_ready = latent ? (cmd_valid && (vcnt >= 2) && !lat_pend) : rsp_ready;
  assign rsp_valid = latent ? (lat_pend && (lat_dly == 2'd2)) : cmd_valid;
  assign rsp_data  = latent ? lat_data : mock_data;

  always @(posedge clk) begin
    if (reset || mock_clr) begin
      kern_idx <= 0;
      get_idx  <= 0;
      lat_pend <= 1'b0;
      lat_dly  <= 2'd0;
      lat_data <= 32'd0;
      vcnt     <= 0;
    end else begin
      if (cmd_valid && cmd_ready) begin
        if (fid == 10'd1) kern_idx <= kern_idx + 1;
        if (fid == 10'd2) get_idx  <= get_idx + 1;
        vcnt <= 0;
        if (latent) begin
          lat_pend <= 1'b1;
          lat_dly  <= 2'd0;
          lat_data <= mock_data;
        end
      end else if (cmd_valid) begin
        vcnt <= vcnt + 1;
      end
      if (lat_pend && (lat_dly < 2'd2)) lat_dly <= lat_dly + 2'd1;
      if (latent && rsp_valid && rsp_ready) lat_pend <= 1'b0;
    end
  end

  // ---------------- monitor ----------------
  logic        outstanding;
  logic        prev_cv, prev_fire;
  logic [9:0]  prev_fid;
  logic [31:0] prev_in0;

  always @(negedge clk) begin
    if (reset) begin
      outstanding = 1'b0;
      prev_cv     = 1'b0;
      prev_fire   = 1'b0;
    end else begin
      if (prev_cv && !prev_fire) begin
        chk("cmd_valid_held", {31'd0, cmd_valid}, 32'd1);
        chk("fid_stable", {22'd0, fid}, {22'd0, prev_fid});
        chk("in0_stable", in0, prev_in0);
      end
      if (outstanding) chk("no_cmd_while_outstanding", {31'd0, cmd_valid}, 32'd0);
      if (cmd_valid && cmd_ready) begin
        fire_cnt++;
        chk("cmd_expected", {31'd0, exp_q.size() != 0}, 32'd1);
        if (exp_q.size() != 0) begin
          logic [41:0] e;
          e = exp_q.pop_front();
          chk("cmd_fid", {22'd0, fid}, {22'd0, e[41:32]});
          chk("cmd_in0", in0, e[31:0]);
          chk("cmd_in1", in1, 32'd0);
          chk("cmd_in2", in2, 32'd0);
        end
      end
      prev_cv   = cmd_valid;
      prev_fire = cmd_valid && cmd_ready;
      prev_fid  = fid;
      prev_in0  = in0;
      if (cmd_valid && cmd_ready) outstanding = 1'b1;
      if (rsp_valid && rsp_ready) outstanding = 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic exp_cmd(input logic [9:0] f, input logic [31:0] d);
    exp_q.push_back({f, d});
  endtask

  task automatic exp_col(input logic [4:0] c, input int nk);
    exp_cmd(10'd0, {27'd0, c});
    for (int k = 0; k < nk; k++) exp_cmd(10'd1, 32'd0);
    exp_cmd(10'd2, 32'd0);
  endtask

  task automatic mock_reset(input logic lat);
    @(negedge clk);
    latent   = lat;
    mock_clr = 1'b1;
    @(negedge clk);
    mock_clr = 1'b0;
  endtask

  // Launch a run and watch until done plus a few cycles. Optionally pulse a
  // second start mid-run.
  task automatic run_cols(input logic [4:0] f, input logic [4:0] l, input bit busy_pulse,
                          output int ndone, output int first_done, output int fires);
    int fires0;
    int post;
    fires0     = fire_cnt;
    ndone      = 0;
    first_done = -1;
    post       = 0;
    @(negedge clk);
    col_first = f;
    col_last  = l;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 400 && post < 4; i++) begin
      if (done) begin
        if (ndone == 0) first_done = i;
        ndone++;
        chk("busy_low_with_done", {31'd0, busy}, 32'd0);
      end
      if (ndone > 0) post++;
      start = busy_pulse && (i == 3);
      if (busy_pulse && i == 3) begin
        col_first = 5'd0;
        col_last  = 5'd1;
      end
      @(negedge clk);
    end
    start = 1'b0;
    fires = fire_cnt - fires0;
    chk("done_pulse_count", ndone, 32'd1);
    chk("exp_q_drained", exp_q.size(), 32'd0);
  endtask

  task automatic check_reset_outputs(input string pfx);
    chk({pfx, "_cmd_valid"}, {31'd0, cmd_valid}, 32'd0);
    chk({pfx, "_rsp_ready"}, {31'd0, rsp_ready}, 32'd0);
    chk({pfx, "_busy"}, {31'd0, busy}, 32'd0);
    chk({pfx, "_done"}, {31'd0, done}, 32'd0);
    chk({pfx, "_err"}, {30'd0, err}, 32'd0);
    chk({pfx, "_result"}, result, 32'd0);
    chk({pfx, "_kernel_count"}, kernel_count, 32'd0);
    chk({pfx, "_fid"}, {22'd0, fid}, 32'd0);
    chk({pfx, "_in0"}, in0, 32'd0);
    chk({pfx, "_state_idle"}, {29'd0, dut.state}, 32'd0);
  endtask

  task automatic load_script1();
    kern_tab[0] = 32'd1;
    kern_tab[1] = 32'd1;
    kern_tab[2] = 32'd1;
    kern_tab[3] = 32'd0;
    kern_len    = 4;
    get_tab[0]  = 32'd5;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int nd, fd, nf;
    bit reached;
    reset     = 1'b1;
    start     = 1'b0;
    col_first = 5'd0;
    col_last  = 5'd0;
    latent    = 1'b0;
    mock_clr  = 1'b0;
    kern_len  = 0;
    for (int i = 0; i < 16; i++) begin
      kern_tab[i] = 32'd0;
      get_tab[i]  = 32'd0;
    end
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    reset = 1'b0;

    // Test 1: combinational responder, col 3, kernels 1,1,1,0, get_ret 5.
    mock_reset(1'b0);
    load_script1();
    exp_col(5'd3, 4);
    run_cols(5'd3, 5'd3, 1'b0, nd, fd, nf);
    chk("t1_fires", nf, 32'd6);
    chk("t1_result", result, 32'd5);
    chk("t1_kernel_count", kernel_count, 32'd4);
    chk("t1_err", {30'd0, err}, 32'd0);

    // Test 2: cols 0..2, kernel runs of 2/1/3, get_ret 5/7/9.
    mock_reset(1'b0);
    kern_tab[0] = 32'd1; kern_tab[1] = 32'd0;
    kern_tab[2] = 32'd0;
    kern_tab[3] = 32'd1; kern_tab[4] = 32'd1; kern_tab[5] = 32'd0;
    kern_len    = 6;
    get_tab[0]  = 32'd5; get_tab[1] = 32'd7; get_tab[2] = 32'd9;
    exp_col(5'd0, 2);
    exp_col(5'd1, 1);
    exp_col(5'd2, 3);
    run_cols(5'd0, 5'd2, 1'b0, nd, fd, nf);
    chk("t2_fires", nf, 32'd12);
    chk("t2_result", result, 32'd21);
    chk("t2_kernel_count", kernel_count, 32'd6);
    chk("t2_err", {30'd0, err}, 32'd0);

    // Test 3: latent responder, same script as test 1.
    mock_reset(1'b1);
    load_script1();
    exp_col(5'd3, 4);
    run_cols(5'd3, 5'd3, 1'b0, nd, fd, nf);
    chk("t3_fires", nf, 32'd6);
    chk("t3_result", result, 32'd5);
    chk("t3_kernel_count", kernel_count, 32'd4);
    chk("t3_err", {30'd0, err}, 32'd0);

    // Test 4: kernel never finishes; limit of 4 fires gives a timeout, no get_ret.
    mock_reset(1'b0);
    kern_len = 0;
    exp_cmd(10'd0, 32'd0);
    for (int k = 0; k < 4; k++) exp_cmd(10'd1, 32'd0);
    run_cols(5'd0, 5'd0, 1'b0, nd, fd, nf);
    chk("t4_fires", nf, 32'd5);
    chk("t4_err", {30'd0, err}, 32'd2);
    chk("t4_kernel_count", kernel_count, 32'd4);
    chk("t4_result", result, 32'd0);

    // Test 5: reversed range from DONE -> range error on the next cycle.
    run_cols(5'd5, 5'd2, 1'b0, nd, fd, nf);
    chk("t5_done_latency", fd, 32'd0);
    chk("t5_fires", nf, 32'd0);
    chk("t5_err", {30'd0, err}, 32'd1);
    chk("t5_result", result, 32'd0);

    // Test 5b: start pulse while busy must be ignored.
    mock_reset(1'b1);
    load_script1();
    exp_col(5'd3, 4);
    run_cols(5'd3, 5'd3, 1'b1, nd, fd, nf);
    chk("t5b_fires", nf, 32'd6);
    chk("t5b_result", result, 32'd5);
    chk("t5b_kernel_count", kernel_count, 32'd4);

    // Test 6: reset in the middle of KERN, then a clean run.
    mock_reset(1'b1);
    load_script1();
    exp_col(5'd3, 4);
    @(negedge clk);
    col_first = 5'd3;
    col_last  = 5'd3;
    start     = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    reached = 1'b0;
    for (int i = 0; i < 100 && !reached; i++) begin
      if (cmd_valid && fid == 10'd1) reached = 1'b1;
      else @(negedge clk);
    end
    chk("t6_reached_kern", {31'd0, reached}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    exp_q.delete();
    check_reset_outputs("t6_rst");
    reset = 1'b0;
    mock_reset(1'b0);
    load_script1();
    exp_col(5'd3, 4);
    run_cols(5'd3, 5'd3, 1'b0, nd, fd, nf);
    chk("t6_fires", nf, 32'd6);
    chk("t6_result", result, 32'd5);
    chk("t6_kernel_count", kernel_count, 32'd4);
    chk("t6_err", {30'd0, err}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
